program_launcher: RTL and testbench

- Parametrised program-launch controller between the board switches/buttons and the CPU system.
- Debounces start/stop buttons and computes the program start address from a slot index.
- Sequences CPU reset (held low, then released) and generates a speed-selectable one-cycle CPU clock enable instead of a derived clock.
- Tracks run/halt state for LEDs and the LCD.

---
 rtl/program_launcher.sv | 201 ++++++++++++++++++++
 tb/tb_program_launcher.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_launcher.sv
// program_launcher: launches a program on the CPU system from the board controls.
// The start and stop buttons are debounced. The launch address is worked out from
// the selected slot. The block then holds the CPU in reset for a fixed number of
// cycles and after that drives a one-cycle clock-enable strobe at a selectable rate.
// It also tracks run/halt state for the LEDs and the LCD.
// Optional feature macro: PROGRAM_LAUNCHER_STEP_EN (single-step button and mode).
module program_launcher #(
  parameter int                NUM_PROGS       = 16,
  parameter int                SEL_W           = 4,
  parameter int                ADDR_W          = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = 16'h8000,
  parameter logic [ADDR_W-1:0] SLOT_STRIDE     = 16'h0100,
  parameter int                DEBOUNCE_CYCLES = 65536,
  parameter int                RESET_CYCLES    = 8,
  parameter int                DIV_W           = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  prog_sel,
  input  logic              start_btn,
  input  logic              stop_btn,
  input  logic [1:0]        speed_sel,
  input  logic              step_mode,
  input  logic              step_btn,
  output logic              cpu_rst_n,
  output logic              cpu_clk_en,
  output logic [ADDR_W-1:0] start_addr,
  output logic [SEL_W-1:0]  current_prog,
  output logic              running,
  output logic              sel_error
);

`ifdef PROGRAM_LAUNCHER_STEP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RESET, RUN, HALT} state_t;

  // Button lanes: bit 0 start, bit 1 stop, bit 2 step (when stepping is built in)
  logic [NB-1:0]           btn_raw;
  logic [NB-1:0]           sync1_q, sync2_q, stab_q, stab_prev_q, press_q;
  logic [NB-1:0][DB_W-1:0] cnt_q;
  logic [SEL_W-1:0]        sel_s1_q, sel_s2_q;
  logic [1:0]              speed_q;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  prog_q, prog_d;
  logic              err_q, err_d;
  logic              launch;

  logic              start_p, stop_p, sel_valid, div_hold, div_match;
  logic [ADDR_W-1:0] addr_calc;
  logic [DIV_W-1:0]  div_mask;

`ifdef PROGRAM_LAUNCHER_STEP_EN
  logic step_pulse_q;
  assign btn_raw  = {step_btn, stop_btn, start_btn};
  assign div_hold = step_mode;
`else
  logic unused_step;
  assign btn_raw     = {stop_btn, start_btn};
  assign div_hold    = 1'b0;
  assign unused_step = step_mode ^ step_btn;
`endif

  // Synchronise the asynchronous inputs, debounce each button and emit press pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stab_q      <= '0;
      stab_prev_q <= '0;
      press_q     <= '0;
      cnt_q       <= '0;
      sel_s1_q    <= '0;
      sel_s2_q    <= '0;
      speed_q     <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      sel_s1_q    <= prog_sel;
      sel_s2_q    <= sel_s1_q;
      speed_q     <= speed_sel;
      stab_prev_q <= stab_q;
      press_q     <= stab_q & ~stab_prev_q;
      for (int b = 0; b < NB; b++) begin
        if (sync2_q[b] == stab_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == DB_MAX) begin
          stab_q[b] <= sync2_q[b];
          cnt_q[b]  <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign start_p   = press_q[0];
  assign stop_p    = press_q[1];
  assign sel_valid = (32'(sel_s2_q) < NUM_PROGS);
  assign addr_calc = BASE_ADDR + ADDR_W'(sel_s2_q) * SLOT_STRIDE;

  // Next-state logic: launch sequencing, run/halt control and the divider count
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    div_d     = div_q;
    addr_d    = addr_q;
    prog_d    = prog_q;
    err_d     = err_q;
    launch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_p) begin
          if (sel_valid) launch = 1'b1;
          else           err_d  = 1'b1;
        end
      end
      RESET: begin
        if (rst_cnt_q == RC_MAX) state_d   = RUN;
        else                     rst_cnt_d = rst_cnt_q + 1'b1;
      end
      RUN: begin
        if (!div_hold) div_d = div_q + 1'b1;
        // a start press takes priority over a stop press in the same cycle
        if (start_p) begin
          if (sel_valid) launch = 1'b1;
          else           err_d  = 1'b1;
        end else if (stop_p) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (start_p) begin
          if (sel_valid) launch = 1'b1;
          else           err_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d   = RESET;
      rst_cnt_d = '0;
      div_d     = '0;
      addr_d    = addr_calc;
      prog_d    = sel_s2_q;
      err_d     = 1'b0;
    end
  end

  // State, launch latches and divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      div_q     <= '0;
      addr_q    <= BASE_ADDR;
      prog_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      div_q     <= div_d;
      addr_q    <= addr_d;
      prog_q    <= prog_d;
      err_q     <= err_d;
    end
  end

  // The strobe fires when the low (DIV_W - speed) bits of the divider are all ones
  assign div_mask  = {DIV_W{1'b1}} >> speed_q;
  assign div_match = (div_q & div_mask) == div_mask;

`ifdef PROGRAM_LAUNCHER_STEP_EN
  // In step mode, issue one strobe in the cycle after each debounced step press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_pulse_q <= 1'b0;
    else        step_pulse_q <= (state_q == RUN) & step_mode & press_q[2];
  end
  assign cpu_clk_en = running && (step_mode ? step_pulse_q : div_match);
`else
  assign cpu_clk_en = running && div_match;
`endif

  assign running      = (state_q == RUN);
  assign cpu_rst_n    = (state_q == RUN) || (state_q == HALT);
  assign start_addr   = addr_q;
  assign current_prog = prog_q;
  assign sel_error    = err_q;

endmodule

// File: tb/tb_program_launcher.sv
// Testbench for program_launcher. It uses short debounce times and 10 valid slots.
// A second instance with a high base address and a large stride checks that the
// start address wraps around.
module tb_program_launcher;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  prog_sel = '0;
  logic        start_btn = 1'b0, stop_btn = 1'b0, step_mode = 1'b0, step_btn = 1'b0;
  logic [1:0]  speed_sel = '0;
  logic        cpu_rst_n, cpu_clk_en, running, sel_error;
  logic [15:0] start_addr;
  logic [3:0]  current_prog;
  logic        w_cpu_rst_n, w_cpu_clk_en, w_running, w_sel_error;
  logic [15:0] w_start_addr;
  logic [3:0]  w_current_prog;

  program_launcher #(.NUM_PROGS(10), .SEL_W(4), .ADDR_W(16), .BASE_ADDR(16'h8000),
    .SLOT_STRIDE(16'h0100), .DEBOUNCE_CYCLES(4), .RESET_CYCLES(8), .DIV_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .prog_sel(prog_sel), .start_btn(start_btn),
    .stop_btn(stop_btn), .speed_sel(speed_sel), .step_mode(step_mode), .step_btn(step_btn),
    .cpu_rst_n(cpu_rst_n), .cpu_clk_en(cpu_clk_en), .start_addr(start_addr),
    .current_prog(current_prog), .running(running), .sel_error(sel_error));

  program_launcher #(.NUM_PROGS(16), .SEL_W(4), .ADDR_W(16), .BASE_ADDR(16'hF000),
    .SLOT_STRIDE(16'h0400), .DEBOUNCE_CYCLES(4), .RESET_CYCLES(8), .DIV_W(5)) u_wrap (
    .clk(clk), .rst_n(rst_n), .prog_sel(prog_sel), .start_btn(start_btn),
    .stop_btn(stop_btn), .speed_sel(speed_sel), .step_mode(step_mode), .step_btn(step_btn),
    .cpu_rst_n(w_cpu_rst_n), .cpu_clk_en(w_cpu_clk_en), .start_addr(w_start_addr),
    .current_prog(w_current_prog), .running(w_running), .sel_error(w_sel_error));

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  // Reference model: run-cycle index since launch, strobe counts, latched values
  bit          mdl_run = 1'b0;
  bit          mdl_err = 1'b0;
  int          n_run = 0;
  int          en_pulses = 0, exp_pulses = 0;
  logic [15:0] mdl_addr = 16'h8000;
  logic [3:0]  mdl_prog = '0;

  function automatic logic [15:0] slot_addr(input int base, input int stride, input int sel);
    logic [31:0] t;
    t = base + sel * stride;
    return t[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock. While the model is in RUN, the strobe is due on every cycle
  // where the run index is a multiple of the period. The period is taken from
  // the speed value that was applied at this edge.
  task automatic tick();
    logic [1:0] sp;
    logic       stp;
    bit         exp_en;
    sp  = speed_sel;
    stp = step_mode;
    @(posedge clk); #1;
`ifndef PROGRAM_LAUNCHER_STEP_EN
    stp = 1'b0;
`endif
    if (mdl_run && !stp) begin
      n_run++;
      exp_en = ((n_run % (32 >> sp)) == 0);
      if (exp_en) exp_pulses++;
      if (running === 1'b1) chk("clk_en_cadence", cpu_clk_en, exp_en);
    end
    if (cpu_clk_en === 1'b1) en_pulses++;
  endtask

  task automatic run_window(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      chk("run_running", running, 1'b1);
      chk("run_cpu_rst_n", cpu_rst_n, 1'b1);
    end
  endtask

  task automatic halt_window(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      chk("halt_running", running, 1'b0);
      chk("halt_clk_en", cpu_clk_en, 1'b0);
      chk("halt_cpu_rst_n", cpu_rst_n, 1'b1);
    end
  endtask

  // The start button is already high. Wait for the launch, then check the latched
  // values, the reset length and the first RUN cycle.
  task automatic launch(input int sel, input bit from_idle, input string tag);
    int t, lows;
    bit seen;
    logic [15:0] ea;
    ea = slot_addr('h8000, 'h100, sel);
    t = 0; seen = 1'b0;
    while (!seen && t < 60) begin
      tick(); t++;
      seen = from_idle ? (start_addr === ea) : (cpu_rst_n === 1'b0);
    end
    chk({tag, "_launch_seen"}, seen, 1'b1);
    mdl_run = 1'b0; mdl_addr = ea; mdl_prog = 4'(sel); mdl_err = 1'b0;
    chk({tag, "_start_addr"}, start_addr, mdl_addr);
    chk({tag, "_current_prog"}, current_prog, mdl_prog);
    chk({tag, "_sel_error"}, sel_error, 1'b0);
    chk({tag, "_rst_running"}, running, 1'b0);
    lows = 1; t = 0;
    while (cpu_rst_n === 1'b0 && t < 40) begin
      tick(); t++;
      if (cpu_rst_n === 1'b0) lows++;
    end
    chk({tag, "_rst_len"}, lows, 8);
    chk({tag, "_run_running"}, running, 1'b1);
    chk({tag, "_first_clk_en"}, cpu_clk_en, 1'b0);
    mdl_run = 1'b1; n_run = 1;
    chk({tag, "_wrap_addr"}, w_start_addr, slot_addr('hF000, 'h400, sel));
  endtask

  // The start button is already high and the slot is invalid for the main instance
  task automatic bad_start(input int sel, input string tag);
    int t;
    bit seen;
    if (!mdl_err) begin
      t = 0; seen = 1'b0;
      while (!seen && t < 60) begin tick(); t++; seen = (sel_error === 1'b1); end
      chk({tag, "_err_seen"}, seen, 1'b1);
    end else begin
      repeat (30) tick();
      chk({tag, "_err_sticky"}, sel_error, 1'b1);
    end
    mdl_err = 1'b1;
    chk({tag, "_addr_kept"}, start_addr, mdl_addr);
    chk({tag, "_prog_kept"}, current_prog, mdl_prog);
    chk({tag, "_still_run"}, running, 1'b1);
    chk({tag, "_wrap_addr"}, w_start_addr, slot_addr('hF000, 'h400, sel));
  endtask

  task automatic press_start(input int sel, input bit from_idle, input string tag);
    prog_sel = 4'(sel);
    repeat (4) tick();
    start_btn = 1'b1;
    if (sel < 10) launch(sel, from_idle, tag);
    else          bad_start(sel, tag);
    start_btn = 1'b0;
    run_window(10);
  endtask

  task automatic press_stop(input string tag);
    int t;
    bit seen;
    stop_btn = 1'b1;
    t = 0; seen = 1'b0;
    while (!seen && t < 40) begin tick(); t++; seen = (running === 1'b0); end
    chk({tag, "_halt_seen"}, seen, 1'b1);
    mdl_run = 1'b0;
    chk({tag, "_halt_rst_n"}, cpu_rst_n, 1'b1);
    chk({tag, "_halt_clk_en"}, cpu_clk_en, 1'b0);
    stop_btn = 1'b0;
    halt_window(10);
  endtask

  initial begin
    int act, sel;
    // Reset values
    tick(); tick();
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_clk_en", cpu_clk_en, 1'b0);
    chk("rst_start_addr", start_addr, 16'h8000);
    chk("rst_current_prog", current_prog, 4'd0);
    chk("rst_running", running, 1'b0);
    chk("rst_sel_error", sel_error, 1'b0);
    rst_n = 1'b1;
    tick();

    // First launch from IDLE, slot 3; slowest speed, then the fastest
    press_start(3, 1'b1, "first");
    run_window(70);
    speed_sel = 2'd3;
    run_window(24);

    // Bouncing start button, then held high: exactly one relaunch
    prog_sel = 4'd5;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      start_btn = (i % 2 == 0);
      repeat (2) begin tick(); chk("bounce_no_launch", cpu_rst_n, 1'b1); end
    end
    start_btn = 1'b1;
    launch(5, 1'b0, "bounce");
    run_window(30);
    start_btn = 1'b0;
    run_window(10);

    // Invalid slot in RUN, then a valid relaunch clears the error
    press_start(12, 1'b0, "badsel");
    run_window(20);
    press_start(1, 1'b0, "goodsel");
    chk("goodsel_addr_8100", start_addr, 16'h8100);

    // Stop, then a long HALT window, then start and stop together
    speed_sel = 2'd2;
    run_window(20);
    press_stop("stop1");
    halt_window(100);
    prog_sel = 4'd7;
    repeat (4) tick();
    start_btn = 1'b1; stop_btn = 1'b1;
    launch(7, 1'b0, "simul");
    start_btn = 1'b0; stop_btn = 1'b0;
    run_window(20);

    // Randomised mix of speed changes, relaunches, bad slots and stop/restart
    for (int it = 0; it < 8; it++) begin
      speed_sel = 2'($urandom_range(0, 3));
      run_window($urandom_range(20, 70));
      act = $urandom_range(0, 2);
      if (act == 0) begin
        sel = $urandom_range(0, 15);
        press_start(sel, 1'b0, "rnd_start");
      end else if (act == 1) begin
        press_stop("rnd_stop");
        press_start($urandom_range(0, 9), 1'b0, "rnd_restart");
      end
    end

    // Step-mode stimulus: three step presses while in RUN
    speed_sel = 2'd0;
    run_window(5);
    step_mode = 1'b1;
    run_window(3);
    en_pulses = 0; exp_pulses = 0;
    for (int p = 0; p < 3; p++) begin
      step_btn = 1'b1; run_window(10);
      step_btn = 1'b0; run_window(10);
    end
`ifdef PROGRAM_LAUNCHER_STEP_EN
    chk("step_pulses", en_pulses, 3);
`else
    chk("nostep_cadence_pulses", en_pulses, exp_pulses);
`endif
    step_mode = 1'b0;
    run_window(40);

    // Asynchronous reset in the middle of a run
    @(posedge clk); #3;
    rst_n = 1'b0;
    mdl_run = 1'b0;
    #1;
    chk("async_rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("async_rst_running", running, 1'b0);
    chk("async_rst_clk_en", cpu_clk_en, 1'b0);
    chk("async_rst_addr", start_addr, 16'h8000);
    chk("async_rst_prog", current_prog, 4'd0);
    chk("async_rst_err", sel_error, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
